reaction_timer_mp: RTL
======================

Name: reaction_timer_mp

Overview:
Multi-player reaction-time referee for the reaction game, parametrised in clock rate, timing resolution, delay range and player count. A start pulse arms the block. It waits a minimum delay plus a random delay, then raises the stimulus. It measures each player's reaction time in ticks and flags false starts. It also reports the winner, ties and a timeout. It sits between the random generator, the debounced player buttons and the display/score logic.

Parameters:
CLK_HZ, 10000000, system clock frequency in Hz.
TICK_HZ, 1000, timing resolution; one tick = CLK_HZ/TICK_HZ clocks (integer divisor, at least 2).
N_PLAYERS, 2, number of response channels (1..8).
MIN_DELAY, 1000, fixed part of the pre-stimulus delay, in ticks.
RAND_W, 12, width of the random delay input, in ticks.
TIME_W, 14, width of each reaction-time field; saturates at all-ones.
TIMEOUT, 5000, ticks after the stimulus before the round is forced to end (less than 2^TIME_W - 1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  round start request; sampled high for one cycle
rand_val  in  RAND_W  random delay from the generator; latched on start acceptance
resp  in  N_PLAYERS  synchronised, debounced player buttons; active high
stim  out  1  stimulus lamp; high only in GO
busy  out  1  high in WAIT and GO
early  out  N_PLAYERS  per-player false-start flags
react_time  out  N_PLAYERS*TIME_W  per-player reaction time in ticks; player i occupies bits [i*TIME_W +: TIME_W]
winner  out  N_PLAYERS  one-hot fastest valid player; 0 if there is none
tie  out  1  two or more players share the fastest time
timeout  out  1  round ended by TIMEOUT
done  out  1  results valid; high in DONE

Behaviour:
- Clock is clk. Reset is rst: one clock, reset synchronous and active-high.
- On rst: the FSM goes to IDLE and all outputs are 0.
- States are IDLE, WAIT, GO and DONE. All outputs are registered.
- Start acceptance:
  - start is accepted in IDLE or DONE only; it is ignored in WAIT and GO.
  - On acceptance at cycle t: target = MIN_DELAY + rand_val (width RAND_W+1 plus enough bits to hold MIN_DELAY, no overflow). Latch target.
  - Also at acceptance: clear early, react_time, winner, tie, timeout and done; clear the tick divider and tick counter; busy = 1 at t+1.
- Tick: a one-cycle strobe every CLK_HZ/TICK_HZ clocks, counted from acceptance. The tick counter increments on each strobe.
- Edge detection:
  - Per player, on resp rising edge, with the previous-value register updated every cycle in all states.
  - A button already held at acceptance never produces an edge.
  - Edges in the acceptance cycle are ignored.
- WAIT state:
  - A resp[i] edge sets early[i]. Early players are disqualified and their react_time stays 0.
  - If all players are early, go to DONE directly; stim is never raised.
  - Otherwise, on the tick where tick count == target, go to GO. stim = 1 the next cycle. Clear the tick counter and divider on entry to GO.
- GO state:
  - The first edge from a non-early, not-yet-recorded player i latches react_time[i] = current tick count (whole ticks since stim rose, rounded down).
  - Later edges from the same player are ignored. Several players may record in the same cycle.
  - When every non-early player has recorded, go to DONE the next cycle.
  - If tick count reaches TIMEOUT, go to DONE with timeout = 1. Unrecorded non-early players get react_time = all-ones.
  - If a recording edge and the timeout occur in the same cycle, the recording wins for that player.
- DONE state:
  - stim = 0, busy = 0, done = 1.
  - winner = the player(s) with the minimum recorded (non-saturated) time; if several share it, the lowest index is set and tie = 1.
  - winner = 0 if nobody recorded. Winner and tie are computed on the cycle of entry to DONE and become valid with done.
  - All results are held until the next accepted start or rst.
- rst mid-round aborts immediately: stim drops the next cycle and no results are retained.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (10 clocks per tick), N_PLAYERS=2, MIN_DELAY=3, RAND_W=4, TIME_W=8, TIMEOUT=20.
1. Normal round: rand_val=2, start; P0 presses 4 ticks after stim, P1 after 7 -> stim rises 5 ticks after start; react_time = {7,4}; winner=01; tie=0; done=1.
2. False start: P1 presses 2 ticks after start, P0 presses 3 ticks after stim -> early=10; react_time[1]=0; winner=01; round ends right after P0's press.
3. All early: both press during WAIT -> DONE with no stim pulse; early=11; winner=00.
4. Timeout: only P0 presses (6 ticks after stim) -> timeout=1 at 20 ticks; react_time = {255,6}; winner=01.
5. Tie and held button: P1 held high through start and releases later; both press in the same cycle 3 ticks after stim -> no early flag for P1; react_time = {3,3}; winner=01; tie=1.
6. Robustness: start during GO is ignored; rst asserted during GO -> next cycle all outputs 0 and state IDLE; a new start then runs a clean round.

Source files
------------

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction-time referee: random pre-stimulus delay,
// per-player timing, false-start detection, winner/tie/timeout.
module reaction_timer_mp #(
  parameter int CLK_HZ    = 10000000,
  parameter int TICK_HZ   = 1000,
  parameter int N_PLAYERS = 2,
  parameter int MIN_DELAY = 1000,
  parameter int RAND_W    = 12,
  parameter int TIME_W    = 14,
  parameter int TIMEOUT   = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [RAND_W-1:0]             rand_val,
  input  logic [N_PLAYERS-1:0]          resp,
  output logic                          stim,
  output logic                          busy,
  output logic [N_PLAYERS-1:0]          early,
  output logic [N_PLAYERS*TIME_W-1:0]   react_time,
  output logic [N_PLAYERS-1:0]          winner,
  output logic                          tie,
  output logic                          timeout,
  output logic                          done
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int TGT_W = RAND_W + 1 + $clog2(MIN_DELAY + 1);
  localparam int CNT_W = (TGT_W > TIME_W) ? TGT_W : TIME_W;
  localparam int RT_W  = N_PLAYERS * TIME_W;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT);
  localparam logic [TIME_W-1:0] SAT      = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div;
  logic [CNT_W-1:0]       r_tcnt;
  logic [TGT_W-1:0]       r_target;
  logic [N_PLAYERS-1:0]   r_prev;
  logic [N_PLAYERS-1:0]   r_early;
  logic [N_PLAYERS-1:0]   r_recd;
  logic [RT_W-1:0]        r_rt;
  logic [N_PLAYERS-1:0]   r_winner;
  logic                   r_tie;
  logic                   r_timeout;
  logic                   r_done;
  logic                   r_stim;
  logic                   r_busy;

  logic                   w_tick;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [N_PLAYERS-1:0]   w_edge;
  logic [N_PLAYERS-1:0]   w_early_nxt;
  logic [N_PLAYERS-1:0]   w_rec;
  logic [N_PLAYERS-1:0]   w_recd_nxt;
  logic                   w_tmo;
  logic                   w_all;
  logic [RT_W-1:0]        w_rt_nxt;
  logic [TIME_W-1:0]      w_best;
  logic [N_PLAYERS-1:0]   w_win;
  logic                   w_tie;
  logic                   w_found;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_cnt_inc   = r_tcnt + 1'b1;
  assign w_edge      = resp & ~r_prev;
  assign w_early_nxt = r_early | w_edge;
  assign w_rec       = (r_state == S_GO) ?
                       (w_edge & ~r_early & ~r_recd) : '0;
  assign w_recd_nxt  = r_recd | w_rec;
  assign w_all       = &(w_recd_nxt | r_early);
  assign w_tmo       = (r_state == S_GO) && w_tick &&
                       (w_cnt_inc == TMO);

  // A press in the timeout cycle is recorded, not saturated.
  always_comb begin
    w_rt_nxt = r_rt;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (w_rec[i])
        w_rt_nxt[i*TIME_W +: TIME_W] = r_tcnt[TIME_W-1:0];
      else if (w_tmo && !w_recd_nxt[i] && !r_early[i])
        w_rt_nxt[i*TIME_W +: TIME_W] = SAT;
    end
  end

  // Strict less-than keeps the lowest index among equals.
  always_comb begin
    w_best  = SAT;
    w_win   = '0;
    w_tie   = 1'b0;
    w_found = 1'b0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (w_recd_nxt[i]) begin
        if (!w_found ||
            w_rt_nxt[i*TIME_W +: TIME_W] < w_best) begin
          w_best   = w_rt_nxt[i*TIME_W +: TIME_W];
          w_win    = '0;
          w_win[i] = 1'b1;
          w_tie    = 1'b0;
          w_found  = 1'b1;
        end else if (w_rt_nxt[i*TIME_W +: TIME_W] == w_best) begin
          w_tie = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    r_prev <= resp;
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_tcnt    <= '0;
      r_target  <= '0;
      r_early   <= '0;
      r_recd    <= '0;
      r_rt      <= '0;
      r_winner  <= '0;
      r_tie     <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_stim    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_WAIT;
            r_target  <= TGT_W'(MIN_DELAY) + TGT_W'(rand_val);
            r_div     <= '0;
            r_tcnt    <= '0;
            r_early   <= '0;
            r_recd    <= '0;
            r_rt      <= '0;
            r_winner  <= '0;
            r_tie     <= 1'b0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          r_early <= w_early_nxt;
          if (w_tick) begin
            r_div  <= '0;
            r_tcnt <= w_cnt_inc;
          end else begin
            r_div  <= r_div + 1'b1;
          end
          if (&w_early_nxt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_tick &&
                       w_cnt_inc >= CNT_W'(r_target)) begin
            r_state <= S_GO;
            r_stim  <= 1'b1;
            r_div   <= '0;
            r_tcnt  <= '0;
          end
        end
        S_GO: begin
          r_recd <= w_recd_nxt;
          r_rt   <= w_rt_nxt;
          if (w_tick) begin
            r_div  <= '0;
            r_tcnt <= w_cnt_inc;
          end else begin
            r_div  <= r_div + 1'b1;
          end
          if (w_all || w_tmo) begin
            r_state   <= S_DONE;
            r_stim    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_winner  <= w_win;
            r_tie     <= w_tie;
            r_timeout <= w_tmo && !w_all;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stim       = r_stim;
  assign busy       = r_busy;
  assign early      = r_early;
  assign react_time = r_rt;
  assign winner     = r_winner;
  assign tie        = r_tie;
  assign timeout    = r_timeout;
  assign done       = r_done;

endmodule
